// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes and the registered result bundle.
// Used by the ALU control decoder and by the execute stage.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_TAGW  = 5;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] result;
      logic                 zero;
      logic                 ovf;
      logic                 illegal;
      logic [ALU_TAGW-1:0]  tag;
   } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: ADD/SUB/AND/OR/XOR with zero, signed-overflow and illegal-op flags.
// Zero latency; no flow control.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             illegal
);

   always_comb begin
      result  = '0;
      ovf     = 1'b0;
      illegal = 1'b0;
      // Unknown op codes match no item and fall through to default.
      case (op)
         ALU_ADD: begin
            result = a + b;
            ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            result = a - b;
            ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         default: illegal = 1'b1;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage, 1-cycle latency, valid/ready output.
// A 2-entry OUT/SKID buffer absorbs back-pressure; in_ready is a flop with no path from out_ready.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int TAGW  = ALU_TAGW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALU_cont,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_ovf,
   output logic             out_illegal,
   output logic [TAGW-1:0]  out_tag
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             ovf;
      logic             illegal;
      logic [TAGW-1:0]  tag;
   } stage_res_t;

   logic [WIDTH-1:0] core_result;
   logic             core_zero;
   logic             core_ovf;
   logic             core_illegal;
   stage_res_t       new_d;
   stage_res_t       out_d;
   stage_res_t       skid_d;
   logic             out_v;
   logic             skid_v;
   logic             rdy_q;
   logic             accept;
   logic             out_free;
   logic             skid_v_n;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op      (ALU_cont),
      .a       (in_a),
      .b       (in_b),
      .result  (core_result),
      .zero    (core_zero),
      .ovf     (core_ovf),
      .illegal (core_illegal)
   );

   assign new_d = '{result: core_result, zero: core_zero, ovf: core_ovf,
                    illegal: core_illegal, tag: in_tag};

   assign accept   = in_valid && rdy_q;
   assign out_free = !out_v || out_ready;
   // SKID empties whenever OUT can take its contents, otherwise it catches an accept.
   assign skid_v_n = out_free ? 1'b0 : (skid_v || accept);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b0;
         out_d  <= '0;
         skid_d <= '0;
      end else begin
         rdy_q  <= !skid_v_n;
         skid_v <= skid_v_n;
         if (out_free) begin
            if (skid_v) begin
               out_d <= skid_d;
               out_v <= 1'b1;
            end else if (accept) begin
               out_d <= new_d;
               out_v <= 1'b1;
            end else begin
               out_v <= 1'b0;
            end
         end else if (accept) begin
            skid_d <= new_d;
         end
      end
   end

   assign in_ready    = rdy_q;
   assign out_valid   = out_v;
   assign out_result  = out_d.result;
   assign out_zero    = out_d.zero;
   assign out_ovf     = out_d.ovf;
   assign out_illegal = out_d.illegal;
   assign out_tag     = out_d.tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage.
module tb_alu_exec_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  ALU_cont;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_ovf;
   logic        out_illegal;
   logic [4:0]  out_tag;

   int checks = 0;
   int errors = 0;

   alu_exec_stage #(.WIDTH(32), .TAGW(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ALU_cont    (ALU_cont),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_zero    (out_zero),
      .out_ovf     (out_ovf),
      .out_illegal (out_illegal),
      .out_tag     (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op with out_ready=1, then check the registered result one edge later.
   task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_ovf, input logic exp_ill);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      ALU_cont  = op;
      in_a      = a;
      in_b      = b;
      in_tag    = tag;
      step();
      in_valid  = 1'b0;
      chk({name, "_valid"},   {31'd0, out_valid}, 32'd1);
      chk({name, "_result"},  out_result, exp_res);
      chk({name, "_zero"},    {31'd0, out_zero}, {31'd0, exp_zero});
      chk({name, "_ovf"},     {31'd0, out_ovf}, {31'd0, exp_ovf});
      chk({name, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
      chk({name, "_tag"},     {27'd0, out_tag}, {27'd0, tag});
   endtask

   initial begin
      logic [3:0] xop;
      logic       x_ill;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      ALU_cont  = 4'b0;
      in_a      = 32'd0;
      in_b      = 32'd0;
      in_tag    = 5'd0;

      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
      chk("rst_result",    out_result, 32'd0);
      chk("rst_flags",     {29'd0, out_zero, out_ovf, out_illegal}, 32'd0);
      chk("rst_tag",       {27'd0, out_tag}, 32'd0);

      step();
      reset = 1'b0;
      chk("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
      step();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

      // Directed ALU vectors.
      do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd7, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      do_op("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 5'd8, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
      do_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 5'd9, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      do_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd10, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
      do_op("or", 4'b0001, 32'h0000_0001, 32'h0000_0002, 5'd11, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
      do_op("xor", 4'b0011, 32'hFFFF_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
      do_op("ill_f", 4'b1111, 32'h0000_0005, 32'h0000_0003, 5'd13, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      // Zero operands make the result 0 whatever a two-state simulator turns X into.
      xop   = 4'bxxxx;
      x_ill = $isunknown(xop) ? 1'b1 : !(xop inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110});
      do_op("ill_x", xop, 32'h0, 32'h0, 5'd14, 32'h0000_0000, 1'b1, 1'b0, x_ill);

      step();
      chk("drain_idle", {31'd0, out_valid}, 32'd0);

      // Back-pressure: three ops while downstream stalls.
      out_ready = 1'b0;
      ALU_cont  = 4'b0010;
      in_b      = 32'h10;
      in_valid  = 1'b1;
      in_a      = 32'd1;
      in_tag    = 5'd1;
      step();
      chk("bp1_in_ready", {31'd0, in_ready}, 32'd1);
      chk("bp1_tag", {27'd0, out_tag}, 32'd1);
      in_a   = 32'd2;
      in_tag = 5'd2;
      step();
      chk("bp2_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp2_tag_hold", {27'd0, out_tag}, 32'd1);
      in_a   = 32'd3;
      in_tag = 5'd3;
      step();
      chk("bp3_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp3_tag_hold", {27'd0, out_tag}, 32'd1);
      step();
      chk("bp4_result_hold", out_result, 32'h11);
      chk("bp4_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_rel_tag2", {27'd0, out_tag}, 32'd2);
      chk("bp_rel_res2", out_result, 32'h12);
      chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_rel_tag3", {27'd0, out_tag}, 32'd3);
      chk("bp_rel_res3", out_result, 32'h13);
      chk("bp_rel_valid3", {31'd0, out_valid}, 32'd1);
      step();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Streaming: one result per cycle, in_ready never drops.
      out_ready = 1'b1;
      ALU_cont  = 4'b0010;
      in_b      = 32'd100;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_a   = i;
         in_tag = i[4:0];
         step();
         chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
         chk("stream_valid", {31'd0, out_valid}, 32'd1);
         chk("stream_tag", {27'd0, out_tag}, i);
         chk("stream_result", out_result, 32'd100 + i);
      end
      in_valid = 1'b0;
      step();
      chk("stream_empty", {31'd0, out_valid}, 32'd0);

      // Fill OUT and SKID, then reset mid-cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      ALU_cont  = 4'b0001;
      in_a      = 32'hA5;
      in_b      = 32'h0;
      in_tag    = 5'd20;
      step();
      in_tag = 5'd21;
      step();
      in_valid = 1'b0;
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_valid", {31'd0, out_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mid_rst_result", out_result, 32'd0);
      step();
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      step();
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
